// File: rtl/freq_decoder.sv
// freq_decoder: measures the rise-to-rise period of a slow divided clock and
// decodes it into a 3-bit programming code. A code is accepted only after it
// has been seen on STABLE_COUNT consecutive periods. Out-of-range periods and
// missing edges raise a sticky error flag.
module freq_decoder #(
  parameter int unsigned HALF_BASE    = 5_000_000,
  parameter int unsigned STABLE_COUNT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clk_in,
  output logic [2:0] code_out,
  output logic       code_valid,
  output logic       changed,
  output logic       error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  // Period thresholds: code k covers [T_(k-1), T_k), with T_k = 3*HALF_BASE*2^k.
  localparam logic [31:0] MIN_P  = 32'(HALF_BASE);
  localparam logic [31:0] T_BASE = 32'(3 * HALF_BASE);
  localparam logic [31:0] T_MAX  = T_BASE << 7;

  localparam int            SW       = $clog2(STABLE_COUNT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_COUNT);

  // Returns {fault, code}: fault for glitches (< MIN_P) and periods >= T_7.
  function automatic logic [3:0] classify(input logic [31:0] period);
    logic [3:0] result;
    result = 4'b1000;
    if (period >= MIN_P) begin
      for (int k = 7; k >= 0; k--) begin
        if (period < (T_BASE << k)) result = {1'b0, 3'(k)};
      end
    end
    return result;
  endfunction

  // Stability count update: a new candidate restarts at 1, repeats saturate.
  function automatic logic [SW-1:0] stab_step(input logic [SW-1:0] cnt,
                                              input logic          match);
    if (!match)             return SW'(1);
    else if (cnt >= STAB_MAX) return STAB_MAX;
    else                    return cnt + SW'(1);
  endfunction

  logic          sync1, sync2, sync3;
  logic          rise;
  logic [1:0]    state;
  logic [31:0]   counter;
  logic [2:0]    candidate;
  logic [SW-1:0] stab;
  logic [3:0]    cls;
  logic          cls_fault;
  logic [2:0]    cls_code;
  logic [SW-1:0] stab_next;

  assign rise      = sync2 & ~sync3;
  assign cls       = classify(counter);
  assign cls_fault = cls[3];
  assign cls_code  = cls[2:0];
  assign stab_next = stab_step(stab, cls_code == candidate);

  // Bring the asynchronous clk_in into the clock domain and keep one extra
  // delayed copy for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= clk_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Measurement FSM, classification, stability tracking and output update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      stab       <= '0;
      candidate  <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      changed    <= 1'b0;
      error      <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        counter    <= '0;
        stab       <= '0;
        code_valid <= 1'b0;
        error      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
            state   <= ARM;
          end
          ARM: begin
            // The first edge only starts a period; it cannot be classified.
            if (rise) begin
              counter <= 32'd1;
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            // A rise takes priority over the timeout so a period of exactly
            // T_7 is reported as a range fault while staying in MEASURE.
            if (rise) begin
              counter <= 32'd1;
              if (cls_fault) begin
                error      <= 1'b1;
                code_valid <= 1'b0;
                stab       <= '0;
              end else begin
                candidate <= cls_code;
                stab      <= stab_next;
                if (stab_next == STAB_MAX) begin
                  changed    <= code_valid && (code_out != cls_code);
                  code_out   <= cls_code;
                  code_valid <= 1'b1;
                  error      <= 1'b0;
                end
              end
            end else if (counter >= T_MAX) begin
              error      <= 1'b1;
              code_valid <= 1'b0;
              stab       <= '0;
              counter    <= '0;
              state      <= ARM;
            end else begin
              counter <= counter + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_decoder.sv
// Testbench for freq_decoder with HALF_BASE=5, STABLE_COUNT=2.
// Directed sequences plus a randomized run against an event-level model.
module tb_freq_decoder;

  localparam int HB = 5;
  localparam int SC = 2;
  localparam int T7 = 3 * HB * 128;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clk_in;
  logic [2:0] code_out;
  logic       code_valid;
  logic       changed;
  logic       error;

  int n_cmp = 0;
  int n_bad = 0;

  freq_decoder #(.HALF_BASE(HB), .STABLE_COUNT(SC)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .clk_in     (clk_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .changed    (changed),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int       period;
    logic [2:0] code;
    logic     chg;
  } vec_t;

  // ---------------- reference model ----------------
  // Tracks rises as edge numbers and derives periods by subtraction; the
  // stability rule is "the last SC classifications since the last clear agree".
  int   edge_n  = 0;
  int   last_r  = 0;
  int   m_mode  = 0;       // 0 idle, 1 waiting for first edge, 2 measuring
  logic [2:0] m_sync = 3'b000;
  int   hist[$];
  int   m_code  = 0;
  logic m_valid = 1'b0;
  logic m_chg   = 1'b0;
  logic m_err   = 1'b0;

  function automatic void ref_classify(input int p, output bit fault, output int code);
    fault = 1'b1;
    code  = 0;
    if (p >= HB) begin
      for (int k = 0; k < 8; k++) begin
        if (p < 3 * HB * (1 << k)) begin
          fault = 1'b0;
          code  = k;
          break;
        end
      end
    end
  endfunction

  initial begin
    bit   m_rise, f;
    int   p, c;
    bit   agree;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_mode = 0; m_sync = 3'b000; hist.delete();
        m_code = 0; m_valid = 1'b0; m_chg = 1'b0; m_err = 1'b0;
      end else begin
        edge_n++;
        m_rise = m_sync[1] && !m_sync[2];
        m_sync = {m_sync[1:0], clk_in};
        m_chg  = 1'b0;
        if (!enable) begin
          m_mode = 0; m_valid = 1'b0; m_err = 1'b0; hist.delete();
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else if (m_mode == 1) begin
          if (m_rise) begin m_mode = 2; last_r = edge_n; end
        end else if (m_rise) begin
          p = edge_n - last_r;
          last_r = edge_n;
          ref_classify(p, f, c);
          if (f) begin
            m_err = 1'b1; m_valid = 1'b0; hist.delete();
          end else begin
            hist.push_back(c);
            if (hist.size() > SC) void'(hist.pop_front());
            agree = (hist.size() == SC);
            foreach (hist[i]) if (hist[i] != c) agree = 1'b0;
            if (agree) begin
              m_chg = m_valid && (m_code != c);
              m_code = c; m_valid = 1'b1; m_err = 1'b0;
            end
          end
        end else if (edge_n - last_r >= T7) begin
          m_err = 1'b1; m_valid = 1'b0; hist.delete(); m_mode = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled after the falling edge.
  initial begin
    repeat (2) @(negedge clock);
    forever begin
      @(negedge clock);
      #1;
      n_cmp++;
      if ({code_out, code_valid, changed, error} !== {3'(m_code), m_valid, m_chg, m_err}) begin
        n_bad++;
        $display("FAIL model@%0t: got code=%0d valid=%b chg=%b err=%b expected code=%0d valid=%b chg=%b err=%b",
                 $time, code_out, code_valid, changed, error, m_code, m_valid, m_chg, m_err);
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clk_in period of p cycles, starting with its rising edge.
  task automatic per(input int p);
    int h;
    h = (p / 2 < 1) ? 1 : p / 2;
    clk_in = 1'b1;
    repeat (h) @(negedge clock);
    clk_in = 1'b0;
    repeat (p - h) @(negedge clock);
  endtask

  // Same as per(), with checks around the rise that opens the period
  // (i.e. the result of the period that just ended). p >= 12.
  task automatic per_chk(input int p, input string name, input logic pre_v,
                         input logic [2:0] e_code, input logic e_v,
                         input logic e_chg, input logic e_err);
    int h;
    h = p / 2;
    clk_in = 1'b1;
    repeat (2) @(negedge clock);
    chk({name, "_pre_valid"}, 32'(code_valid), 32'(pre_v));
    @(negedge clock);
    chk({name, "_code"},  32'(code_out),   32'(e_code));
    chk({name, "_valid"}, 32'(code_valid), 32'(e_v));
    chk({name, "_chg"},   32'(changed),    32'(e_chg));
    chk({name, "_err"},   32'(error),      32'(e_err));
    @(negedge clock);
    chk({name, "_chg_clr"}, 32'(changed), 32'd0);
    repeat (h - 4) @(negedge clock);
    clk_in = 1'b0;
    repeat (p - h) @(negedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl[8];
    int   cnt, sel, p, reps;
    bit   got;

    tbl[0] = '{12,   3'd0, 1'b0};
    tbl[1] = '{22,   3'd1, 1'b1};
    tbl[2] = '{42,   3'd2, 1'b1};
    tbl[3] = '{82,   3'd3, 1'b1};
    tbl[4] = '{162,  3'd4, 1'b1};
    tbl[5] = '{322,  3'd5, 1'b1};
    tbl[6] = '{642,  3'd6, 1'b1};
    tbl[7] = '{1282, 3'd7, 1'b1};

    reset = 1'b0; enable = 1'b0; clk_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_code",  32'(code_out),   32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_chg",   32'(changed),    32'd0);
    chk("rst_err",   32'(error),      32'd0);
    reset = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);

    // Lock at code 0: arming rise + 2 periods, accepted 3 edges after the drive.
    per(12); per(12);
    per_chk(12, "lock0", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Switch to period 42: one period of hold, then code 2 with a changed pulse.
    per_chk(42, "sw_a", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    per_chk(42, "sw_b", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    per_chk(42, "sw_c", 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);

    // Back to code 0, then a 4-cycle glitch period, then recovery.
    per(12); per(12); per(12);
    per(4);
    per_chk(12, "glitch",    1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    per_chk(12, "glitch_r1", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    per_chk(12, "glitch_r2", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Static clk_in after a last rise: timeout 1920 cycles after the rise is
    // detected (2 synchronizer edges), visible one edge later.
    clk_in = 1'b1;
    cnt = 0; got = 1'b0;
    while (cnt < 2500 && !got) begin
      @(negedge clock);
      cnt++;
      if (cnt == 6) clk_in = 1'b0;
      if (error === 1'b1) got = 1'b1;
    end
    chk("timeout_cycles", 32'(cnt), 32'(3 + T7));
    chk("timeout_valid",  32'(code_valid), 32'd0);
    // After a timeout the next rise only arms.
    per(12);
    per_chk(12, "to_arm2", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    per_chk(12, "to_arm3", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Period of exactly T_7: rise wins over timeout, range fault, stays measuring.
    per(1920);
    per_chk(12, "rng",    1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    per_chk(12, "rng_r1", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    per_chk(12, "rng_r2", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Every code in turn.
    for (int i = 0; i < 8; i++) begin
      per(tbl[i].period); per(tbl[i].period);
      per_chk(tbl[i].period, $sformatf("tbl%0d", i), 1'b1, tbl[i].code, 1'b1, tbl[i].chg, 1'b0);
    end

    // Enable drop: code_valid clears on the next edge, code_out holds.
    enable = 1'b0;
    @(negedge clock);
    chk("en_valid", 32'(code_valid), 32'd0);
    chk("en_err",   32'(error),      32'd0);
    chk("en_chg",   32'(changed),    32'd0);
    chk("en_code",  32'(code_out),   32'd7);
    repeat (3) @(negedge clock);
    enable = 1'b1;
    per(22);
    per_chk(22, "en_r2", 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    per_chk(22, "en_r3", 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a measured period.
    clk_in = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mrst_code",  32'(code_out),   32'd0);
    chk("mrst_valid", 32'(code_valid), 32'd0);
    chk("mrst_chg",   32'(changed),    32'd0);
    chk("mrst_err",   32'(error),      32'd0);
    @(negedge clock);
    clk_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    per(12);
    per_chk(12, "rst_r2", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    per_chk(12, "rst_r3", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic, checked by the model every cycle.
    for (int it = 0; it < 100; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 6) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 15)) @(negedge clock);
        enable = 1'b1;
      end else if (sel < 9) begin
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
      end else if (sel < 11) begin
        clk_in = 1'b0;
        repeat ($urandom_range(1900, 2000)) @(negedge clock);
      end else begin
        if (sel < 20)      p = $urandom_range(2, 16);
        else if (sel < 90) p = $urandom_range(10, 200);
        else               p = $urandom_range(300, 1000);
        reps = $urandom_range(1, 4);
        repeat (reps) per(p);
      end
    end
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_decoder.md
FREQ_DECODER -- requirements
Module: freq_decoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter HALF_BASE, default 5_000_000: base half-period in clock cycles for code 0.
REQ-003 Parameter STABLE_COUNT, default 2: number of consecutive matching periods required before a code is accepted.
REQ-004 Ports SHALL be:
- clock  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- clk_in  input  1  divided clock under measurement; treated as asynchronous.
- code_out  output  3  decoded programming code 0..7.
- code_valid  output  1  code_out holds an accepted code.
- changed  output  1  one-cycle pulse when an accepted code differs from the previous accepted code.
- error  output  1  sticky fault flag (period out of range or timeout).

Function
REQ-005 clk_in SHALL pass through a 2-flop synchronizer, followed by a third flop; rise = sync2 & ~sync3.
REQ-006 Thresholds SHALL be computed at elaboration: T_k = 3*HALF_BASE*2^k for k=0..7, and MIN_P = HALF_BASE; all counters and thresholds are 32-bit unsigned.
REQ-007 FSM states SHALL be IDLE, ARM and MEASURE.
REQ-008 IDLE: counter=0, code_valid=0; go to ARM when enable=1.
REQ-009 ARM: wait for rise; on rise, counter<=1 and go to MEASURE.
REQ-010 MEASURE: counter increments each cycle; on rise, period=counter is classified, and counter<=1 in the same cycle.
REQ-011 Classification SHALL be: period<MIN_P is a glitch fault; otherwise code = smallest k with period<T_k; period>=T_7 is a range fault.
REQ-012 A fault SHALL set error=1, clear code_valid, reset the stability count to 0, and leave the FSM in MEASURE.
REQ-013 If counter reaches T_7 with no rise, the block SHALL set error=1, clear code_valid, and go to ARM (timeout).
REQ-014 Stability tracking:
- A candidate register and a stability count SHALL be kept.
- A classification equal to the candidate increments the count, saturating at STABLE_COUNT.
- A classification different from the candidate loads the candidate and sets the count to 1.
REQ-015 When the count reaches STABLE_COUNT:
- code_out<=candidate, code_valid<=1, error<=0.
- changed<=1 for exactly one cycle, only if code_valid was already 1 and code_out differs from the candidate.
REQ-016 While a new candidate is accumulating, code_out and code_valid SHALL hold their last accepted values.
REQ-017 Latency: code_out/code_valid update on the clock edge after the cycle in which the rise that completes the STABLE_COUNT-th matching period is detected.
REQ-018 enable=0 SHALL take effect on the next edge: go to IDLE, clear code_valid, stability count and changed, and clear error; code_out holds its value.
REQ-019 If rise and timeout occur in the same cycle, rise SHALL win (classify, giving a range fault).

Reset
REQ-020 On reset=0, asynchronously:
- state=IDLE, counter=0, stability count=0, candidate=0.
- code_out=0, code_valid=0, changed=0, error=0.
- All synchronizer flops=0.
REQ-021 Reset asserted mid-measurement SHALL discard any partial period; after release, the first rise only arms the block.

Verification (HALF_BASE=5, STABLE_COUNT=2; a source toggling every 5*2^k+1 cycles gives period 10*2^k+2)
REQ-022 Square wave with period 12, enable=1 -> after 1 arming rise and 2 full periods: code_out=0, code_valid=1, changed=0, error=0.
REQ-023 Stream locked at code 0, period switched to 42 -> code_out stays 0 for 1 period, then code_out=2 with a single-cycle changed=1; code_valid never drops.
REQ-024 Each of periods 12, 22, 42, 82, 162, 322, 642, 1282 -> code_out=0..7 respectively.
REQ-025 clk_in held static after lock -> error=1 and code_valid=0 exactly 1920 cycles after the last counted rise; state=ARM.
REQ-026 Single period of 4 cycles inside a stable stream -> error=1, code_valid=0; then 2 good periods -> code_valid=1, error=0.
REQ-027 reset pulsed low during MEASURE, and separately enable dropped -> all outputs 0 immediately on reset; on enable drop, code_valid=0 next edge; relock needs 1 arming rise plus 2 periods.
